// File: rtl/sar_scan_sequencer.sv
// Periodic multi-channel scan controller for a SAR ADC core.
// A programmable timer launches a scan; each channel is settled, converted
// 2^OsrLog2 times, averaged by truncation and offered on a valid/ready port.
module sar_scan_sequencer #(
    parameter int Resolution   = 8,
    parameter int Channels     = 4,
    parameter int OsrLog2      = 2,
    parameter int SettleCycles = 2,
    parameter int PeriodWidth  = 16,
    localparam int ChanW       = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [PeriodWidth-1:0] period_i,
    input  logic                   clr_i,
    output logic                   sar_start_o,
    input  logic                   sar_rdy_i,
    input  logic [Resolution-1:0]  sar_result_i,
    output logic [ChanW-1:0]       chan_o,
    output logic [Resolution-1:0]  data_o,
    output logic [ChanW-1:0]       tag_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic                   overrun_o,
    output logic                   missed_o
);

    localparam int AccW = Resolution + OsrLog2;
    localparam int NW   = (OsrLog2 > 0) ? OsrLog2 : 1;
    localparam int SetW = $clog2(SettleCycles + 2);

    localparam logic [NW-1:0]    NLast      = NW'((1 << OsrLog2) - 1);
    localparam logic [SetW-1:0]  SettleLast = SetW'((SettleCycles > 0) ? SettleCycles - 1 : 0);
    localparam logic [ChanW-1:0] ChanLast   = ChanW'(Channels - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PeriodWidth-1:0] cnt_q;
    logic                   tick;
    logic [ChanW-1:0]       chan_q, chan_d;
    logic [AccW-1:0]        acc_q, acc_d;
    logic [NW-1:0]          n_q, n_d;
    logic [SetW-1:0]        settle_q, settle_d;
    logic [Resolution-1:0]  data_q, data_d;
    logic [ChanW-1:0]       tag_q, tag_d;
    logic                   valid_q, valid_d;
    logic                   start_q;
    logic                   busy_q;
    logic                   overrun_q, overrun_d;
    logic                   missed_q, missed_d;
    logic [Resolution-1:0]  avg;

    assign tick = en_i && (cnt_q == period_i);
    // Upper Resolution bits of the accumulator are the truncated average.
    assign avg  = acc_q[OsrLog2 +: Resolution];

    // Scan-period timer: free-running while enabled, held at zero otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i || (cnt_q == period_i)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // State and datapath registers; start/busy are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            settle_q  <= '0;
            data_q    <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            settle_q  <= settle_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            start_q   <= (state_d == START);
            busy_q    <= (state_d != IDLE);
            overrun_q <= overrun_d;
            missed_q  <= missed_d;
        end
    end

    // Next-state, accumulation, output-port and sticky-flag logic.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        acc_d     = acc_q;
        n_d       = n_q;
        settle_d  = settle_q;
        data_d    = data_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        missed_d  = missed_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // Clear first so that a same-cycle set event overrides it.
        if (clr_i) begin
            overrun_d = 1'b0;
            missed_d  = 1'b0;
        end

        if (tick && (state_q != IDLE)) begin
            missed_d = 1'b1;
        end

        if (!en_i) begin
            state_d  = IDLE;
            chan_d   = '0;
            acc_d    = '0;
            n_d      = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_d  = SETTLE;
                        chan_d   = '0;
                        acc_d    = '0;
                        n_d      = '0;
                        settle_d = '0;
                    end
                end
                SETTLE: begin
                    if (settle_q == SettleLast) begin
                        state_d = START;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                START: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (sar_rdy_i) begin
                        acc_d = acc_q + AccW'(sar_result_i);
                        if (n_q == NLast) begin
                            state_d = DONE;
                        end else begin
                            n_d     = n_q + 1'b1;
                            state_d = START;
                        end
                    end
                end
                DONE: begin
                    if (!valid_q || ready_i) begin
                        data_d  = avg;
                        tag_d   = chan_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    acc_d = '0;
                    n_d   = '0;
                    if (chan_q == ChanLast) begin
                        state_d = IDLE;
                        chan_d  = '0;
                    end else begin
                        state_d  = SETTLE;
                        chan_d   = chan_q + 1'b1;
                        settle_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign sar_start_o = start_q;
    assign chan_o      = chan_q;
    assign data_o      = data_q;
    assign tag_o       = tag_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;
    assign missed_o    = missed_q;

endmodule
